// File: rtl/carry_save_resolver_if.sv
// Handshake bundle for the carry-save resolver. The upstream side supplies the redundant operand
// and out_ready; the resolver side returns in_ready, out_valid and the binary sum.
interface carry_save_resolver_if #(
    parameter int BIT_LEN = 64,
    parameter int OUT_LEN = BIT_LEN + 3
);
    logic               in_valid;
    logic               in_ready;
    logic [BIT_LEN-1:0] S;
    logic [BIT_LEN-1:0] Cout;
    logic [BIT_LEN-1:0] Cout1;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_LEN-1:0] sum;

    modport master (
        output in_valid, S, Cout, Cout1, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, S, Cout, Cout1, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/carry_save_resolver.sv
// Resolves the redundant S + 2*Cout + 4*Cout1 triple into one binary integer,
// one SEG_LEN-bit segment per cycle, starting at the least significant segment.
module carry_save_resolver #(
    parameter int BIT_LEN = 64,
    parameter int SEG_LEN = 16
) (
    input  logic clk,
    input  logic reset,
    carry_save_resolver_if.slave bus
);
    localparam int OUT_LEN  = BIT_LEN + 3;
    localparam int NUM_SEGS = (OUT_LEN + SEG_LEN - 1) / SEG_LEN;
    localparam int EXT_LEN  = NUM_SEGS * SEG_LEN;
    localparam int SW       = SEG_LEN + 2;
    localparam int CNT_W    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         carry_r;
    logic               out_valid_r;
    logic [EXT_LEN-1:0] res_r;
    logic [EXT_LEN-1:0] a_r;
    logic [EXT_LEN-1:0] b_r;
    logic [EXT_LEN-1:0] d_r;
    logic [SW-1:0]      seg_add;
    logic               last;

    assign last          = (cnt == CNT_W'(NUM_SEGS - 1));
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = res_r[OUT_LEN-1:0];

    // Three segments plus a carry of at most 2 stay below 3*2^SEG_LEN, so a 2-bit carry suffices.
    always_comb begin
        seg_add = SW'(a_r[SEG_LEN-1:0]) + SW'(b_r[SEG_LEN-1:0])
                + SW'(d_r[SEG_LEN-1:0]) + SW'(carry_r);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            carry_r     <= 2'd0;
            out_valid_r <= 1'b0;
            res_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt     <= '0;
                        carry_r <= 2'd0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NUM_SEGS; k++) begin
                        if (cnt == CNT_W'(k)) res_r[k*SEG_LEN +: SEG_LEN] <= seg_add[SEG_LEN-1:0];
                    end
                    carry_r <= seg_add[SW-1:SEG_LEN];
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand shifters carry no reset: they are reloaded on every accept before being used.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            a_r <= EXT_LEN'(bus.S);
            b_r <= EXT_LEN'({bus.Cout, 1'b0});
            d_r <= EXT_LEN'({bus.Cout1, 2'b0});
        end else if (state == RUN) begin
            a_r <= a_r >> SEG_LEN;
            b_r <= b_r >> SEG_LEN;
            d_r <= d_r >> SEG_LEN;
        end
    end

    // The exact result fits OUT_LEN bits, so the final carry and the padding bits are always zero.
    always @(posedge clk) begin
        if (!reset && state == RUN && last) begin
            a_final_carry_zero: assert (seg_add[SW-1:SEG_LEN] == 2'd0);
        end
    end

    if (EXT_LEN > OUT_LEN) begin : g_pad_check
        always @(posedge clk) begin
            if (!reset && state == DONE) begin
                a_pad_zero: assert (res_r[EXT_LEN-1:OUT_LEN] == '0);
            end
        end
    end
endmodule

// File: tb/tb_carry_save_resolver.sv
// Directed and randomized checks of carry_save_resolver against an arithmetic reference sum.
module tb_carry_save_resolver;
    localparam int BIT_LEN = 64;
    localparam int OUT_LEN = BIT_LEN + 3;
    localparam int LAT     = 5;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    carry_save_resolver_if #(.BIT_LEN(BIT_LEN)) bus ();

    carry_save_resolver #(.BIT_LEN(BIT_LEN), .SEG_LEN(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OUT_LEN-1:0] ref_sum(input logic [BIT_LEN-1:0] s, c, c1);
        return OUT_LEN'(s) + OUT_LEN'(c) * 2 + OUT_LEN'(c1) * 4;
    endfunction

    function automatic logic [BIT_LEN-1:0] rnd64();
        logic [BIT_LEN-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '1;
            1:       v = '0;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    // One complete operation: idle gap, accept, wait for result, optional backpressure, release.
    task automatic run_op(input logic [BIT_LEN-1:0] s, c, c1,
                          input int pre_gap, input int hold, input bit pulse);
        logic [OUT_LEN-1:0] exp;
        int k;
        exp = ref_sum(s, c, c1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (pre_gap) tick();
        bus.S = s;
        bus.Cout = c;
        bus.Cout1 = c1;
        bus.in_valid = 1'b1;
        check("in_ready_idle", 128'(bus.in_ready), 128'(1));
        tick();
        bus.in_valid = 1'b0;
        bus.S = rnd64();
        bus.Cout = rnd64();
        bus.Cout1 = rnd64();
        k = 0;
        while (!bus.out_valid && k < 20) begin
            check("in_ready_run", 128'(bus.in_ready), 128'(0));
            tick();
            k++;
        end
        check("latency", 128'(k), 128'(LAT));
        check("sum", 128'(bus.sum), 128'(exp));
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                bus.in_valid = 1'b1;
                bus.S = rnd64();
                bus.Cout = rnd64();
                bus.Cout1 = rnd64();
            end
            tick();
            check("bp_out_valid", 128'(bus.out_valid), 128'(1));
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
            check("bp_sum", 128'(bus.sum), 128'(exp));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_out_valid", 128'(bus.out_valid), 128'(0));
        check("release_in_ready", 128'(bus.in_ready), 128'(1));
    endtask

    initial begin
        logic [BIT_LEN-1:0] top_bit;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.S = '0;
        bus.Cout = '0;
        bus.Cout1 = '0;
        tick();
        tick();
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_sum", 128'(bus.sum), 128'(0));
        reset = 1'b0;
        tick();

        run_op(64'd1, 64'd1, 64'd1, 0, 0, 1'b0);
        check("basic_ref", 128'(ref_sum(64'd1, 64'd1, 64'd1)), 128'd7);
        run_op('1, '1, '1, 1, 0, 1'b0);
        check("max_ref", 128'(ref_sum('1, '1, '1)), 128'h6_FFFF_FFFF_FFFF_FFF9);
        run_op(64'hFFFF, 64'h1, 64'h0, 0, 0, 1'b0);
        top_bit = '0;
        top_bit[63] = 1'b1;
        run_op('0, '0, top_bit, 2, 0, 1'b0);

        // Backpressure with a competing operand offered, then immediate next accept.
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA, 0, 10, 1'b1);
        run_op(64'h1111, 64'h2222, 64'h3333, 0, 0, 1'b0);

        // Asynchronous reset two cycles into an operation.
        bus.S = rnd64();
        bus.Cout = rnd64();
        bus.Cout1 = rnd64();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_sum", 128'(bus.sum), 128'(0));
        check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
        tick();
        reset = 1'b0;
        repeat (8) begin
            tick();
            check("midrst_no_result", 128'(bus.out_valid), 128'(0));
        end
        run_op(64'hDEAD_BEEF_0000_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            run_op(rnd64(), rnd64(), rnd64(), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
